// File: rtl/lcd_rx_pkg.sv
// ============================================================================
// Module : lcd_rx_pkg
// Brief  : Shared types, CRC constants and CRC helper for the LCD receiver.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package lcd_rx_pkg;

  typedef struct packed {
    logic       dc;
    logic [7:0] data;
  } lcd_rx_entry_t;

  localparam logic [15:0] CRC16_POLY = 16'h1021;
  localparam logic [15:0] CRC16_INIT = 16'hFFFF;

  // CRC-16/CCITT-FALSE over one byte, MSB first, no reflection.
  function automatic logic [15:0] crc16_byte(input logic [15:0] crc_in, input logic [7:0] data_in);
    logic [15:0] c;
    c = crc_in ^ {data_in, 8'h00};
    for (int i = 0; i < 8; i++) begin
      c = c[15] ? ((c << 1) ^ CRC16_POLY) : (c << 1);
    end
    return c;
  endfunction

endpackage

`default_nettype wire

// File: rtl/lcd_rx_fifo.sv
// ============================================================================
// Module : lcd_rx_fifo
// Brief  : Synchronous FIFO of lcd_rx_entry_t with combinational head output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_rx_fifo
  import lcd_rx_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  lcd_rx_entry_t            push_data,
  output logic                     full,
  input  logic                     pop,
  output lcd_rx_entry_t            pop_data,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);

  lcd_rx_entry_t   mem_q [DEPTH];
  lcd_rx_entry_t   mem_d [DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [AW:0]     count_q, count_d;
  logic            pop_ok;
  logic            push_ok;

  assign empty    = (count_q == '0);
  assign full     = (count_q == (AW+1)'(DEPTH));
  assign level    = count_q;
  assign pop_data = mem_q[rd_ptr_q];
  assign pop_ok   = pop && !empty;
  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign push_ok  = push && (!full || pop_ok);

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = push_data;
      wr_ptr_d        = wr_ptr_q + AW'(1);
    end
    if (pop_ok) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push_ok && !pop_ok) begin
      count_d = count_q + (AW+1)'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - (AW+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/lcd_rx_capture.sv
// ============================================================================
// Module : lcd_rx_capture
// Brief  : LCD interface receiver: pad sync, edge detect, byte assembly, FIFO.
//          Optional CRC-16 of data bytes enabled by macro LCD_RX_CRC_EN.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module lcd_rx_capture
  import lcd_rx_pkg::*;
#(
  parameter int FIFO_DEPTH  = 8,
  parameter int SYNC_STAGES = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          cfg_en,
  input  logic                          cfg_parallel,
  input  logic                          pad_lcd_clk,
  input  logic [7:0]                    pad_lcd_dat,
  input  logic                          pad_lcd_dc,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [7:0]                    out_data,
  output logic                          out_dc,
  output logic [$clog2(FIFO_DEPTH):0]   level,
  output logic                          overflow,
  input  logic                          overflow_clr,
  input  logic                          crc_clr,
  output logic [15:0]                   crc
);

  // All pad bits share one chain so their relative skew is preserved.
  logic [9:0]      sync_q [SYNC_STAGES];
  logic [9:0]      sync_d [SYNC_STAGES];
  logic            sclk, sdc;
  logic [7:0]      sdat;
  logic            prev_q, prev_d;
  logic            en_q, en_d;
  logic            rise;
  logic [7:0]      sr_q, sr_d, sr_shift;
  logic [2:0]      cnt_q, cnt_d;
  logic            wr;
  lcd_rx_entry_t   wr_entry;
  logic            ovf_q, ovf_d;
  lcd_rx_entry_t   hold_q, hold_d;
  lcd_rx_entry_t   head;
  logic            fifo_full, fifo_empty, pop, accept;

  always_comb begin
    sync_d[0] = {pad_lcd_dc, pad_lcd_dat, pad_lcd_clk};
    for (int i = 1; i < SYNC_STAGES; i++) sync_d[i] = sync_q[i-1];
  end

  assign {sdc, sdat, sclk} = sync_q[SYNC_STAGES-1];
  assign prev_d   = sclk;
  assign en_d     = cfg_en;
  assign rise     = en_q && sclk && !prev_q;
  assign sr_shift = {sr_q[6:0], sdat[0]};

  always_comb begin
    sr_d     = sr_q;
    cnt_d    = cnt_q;
    wr       = 1'b0;
    wr_entry = '{dc: sdc, data: sdat};
    if (!cfg_en) begin
      cnt_d = '0;
    end else if (cfg_parallel) begin
      wr = rise;
    end else if (sdat[1]) begin
      cnt_d = '0;
    end else if (rise) begin
      sr_d  = sr_shift;
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) begin
        wr            = 1'b1;
        wr_entry.data = sr_shift;
      end
    end
  end

  assign pop    = !fifo_empty && out_ready;
  assign accept = wr && (!fifo_full || pop);

  lcd_rx_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (accept),
    .push_data (wr_entry),
    .full      (fifo_full),
    .pop       (pop),
    .pop_data  (head),
    .empty     (fifo_empty),
    .level     (level)
  );

  always_comb begin
    ovf_d = ovf_q;
    if (wr && !accept) ovf_d = 1'b1;
    else if (overflow_clr) ovf_d = 1'b0;
  end

  // Last popped entry is presented while the FIFO is empty.
  assign hold_d    = pop ? head : hold_q;
  assign out_valid = !fifo_empty;
  assign out_data  = fifo_empty ? hold_q.data : head.data;
  assign out_dc    = fifo_empty ? hold_q.dc : head.dc;
  assign overflow  = ovf_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= '0;
      prev_q <= 1'b0;
      en_q   <= 1'b0;
      sr_q   <= '0;
      cnt_q  <= '0;
      ovf_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      sync_q <= sync_d;
      prev_q <= prev_d;
      en_q   <= en_d;
      sr_q   <= sr_d;
      cnt_q  <= cnt_d;
      ovf_q  <= ovf_d;
      hold_q <= hold_d;
    end
  end

`ifdef LCD_RX_CRC_EN
  logic [15:0] crc_q, crc_d;

  always_comb begin
    crc_d = crc_q;
    if (crc_clr) crc_d = CRC16_INIT;
    else if (accept && wr_entry.dc) crc_d = crc16_byte(crc_q, wr_entry.data);
  end

  always_ff @(posedge clk) begin
    if (rst) crc_q <= CRC16_INIT;
    else     crc_q <= crc_d;
  end

  assign crc = crc_q;
`else
  logic unused_crc_clr;
  assign unused_crc_clr = crc_clr;
  assign crc            = 16'h0000;
`endif

endmodule

`default_nettype wire
